gin_stream_tagger: RTL and testbench

- Upstream feeder for the global input network's tag and data FIFO pair.
- Accepts a valid/ready word stream from the global buffer and attaches a (row_tag, col_tag) multicast address to each word.
- Tags come from a programmable row/column sweep pattern repeated over N passes.
- Writes each word and its tags into the data and tags FIFOs in the same cycle, honouring both full flags.

---
 rtl/gin_stream_tagger.sv | 172 +++++++++++++++++
 tb/tb_gin_stream_tagger.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gin_stream_tagger.sv
// gin_stream_tagger: feeds the global input network's data and tags FIFO pair.
// Each accepted stream word is written to the data FIFO while its
// (row_tag, col_tag) multicast address is written to the tags FIFO in the
// same cycle. Tags follow a row/column sweep that is repeated for N passes.
// Optional build macro GIN_TAGGER_PERF_EN adds a saturating backpressure
// stall counter on output stall_cycles.
module gin_stream_tagger #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int PASS_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_row_base,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_num_rows,
  input  logic [COL_TAG_WIDTH-1:0] cfg_col_base,
  input  logic [COL_TAG_WIDTH-1:0] cfg_num_cols,
  input  logic [PASS_WIDTH-1:0]    cfg_num_passes,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic [ROW_TAG_WIDTH-1:0] row_tag,
  output logic [COL_TAG_WIDTH-1:0] col_tag,
  output logic                     data_wr_en,
  output logic                     tags_wr_en,
  input  logic                     data_full,
  input  logic                     tags_full,
  output logic                     busy,
  output logic                     done
`ifdef GIN_TAGGER_PERF_EN
  ,
  output logic [15:0]              stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ROW_TAG_WIDTH-1:0] row_base_q, row_base_d;
  logic [ROW_TAG_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [COL_TAG_WIDTH-1:0] col_base_q, col_base_d;
  logic [COL_TAG_WIDTH-1:0] num_cols_q, num_cols_d;
  logic [PASS_WIDTH-1:0]    num_passes_q, num_passes_d;
  logic [ROW_TAG_WIDTH-1:0] row_idx_q, row_idx_d;
  logic [COL_TAG_WIDTH-1:0] col_idx_q, col_idx_d;
  logic [PASS_WIDTH-1:0]    pass_idx_q, pass_idx_d;
  logic                     accept;
  logic                     last_col, last_row, last_pass;

  // Handshake and FIFO-facing outputs; a single accept drives both write
  // enables so the two FIFOs can never drift apart in occupancy.
  always_comb begin
    s_ready    = (state_q == RUN) & ~data_full & ~tags_full;
    accept     = s_valid & s_ready;
    data_wr_en = accept;
    tags_wr_en = accept;
    data_in    = s_data;
    row_tag    = row_base_q + row_idx_q;
    col_tag    = col_base_q + col_idx_q;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    last_col   = (col_idx_q == num_cols_q - COL_TAG_WIDTH'(1));
    last_row   = (row_idx_q == num_rows_q - ROW_TAG_WIDTH'(1));
    last_pass  = (pass_idx_q == num_passes_q - PASS_WIDTH'(1));
  end

  // Next-state logic: config capture on start, then the nested
  // column/row/pass sweep that advances only on an accepted word.
  always_comb begin
    state_d      = state_q;
    row_base_d   = row_base_q;
    num_rows_d   = num_rows_q;
    col_base_d   = col_base_q;
    num_cols_d   = num_cols_q;
    num_passes_d = num_passes_q;
    row_idx_d    = row_idx_q;
    col_idx_d    = col_idx_q;
    pass_idx_d   = pass_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_base_d   = cfg_row_base;
          num_rows_d   = (cfg_num_rows == '0) ? ROW_TAG_WIDTH'(1) : cfg_num_rows;
          col_base_d   = cfg_col_base;
          num_cols_d   = (cfg_num_cols == '0) ? COL_TAG_WIDTH'(1) : cfg_num_cols;
          num_passes_d = cfg_num_passes;
          row_idx_d    = '0;
          col_idx_d    = '0;
          pass_idx_d   = '0;
          state_d      = (cfg_num_passes != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept) begin
          col_idx_d = col_idx_q + COL_TAG_WIDTH'(1);
          if (last_col) begin
            col_idx_d = '0;
            row_idx_d = row_idx_q + ROW_TAG_WIDTH'(1);
            if (last_row) begin
              row_idx_d  = '0;
              pass_idx_d = pass_idx_q + PASS_WIDTH'(1);
              if (last_pass) begin
                pass_idx_d = '0;
                state_d    = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched config and sweep counters; reset abandons any sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_base_q   <= '0;
      num_rows_q   <= '0;
      col_base_q   <= '0;
      num_cols_q   <= '0;
      num_passes_q <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      pass_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      row_base_q   <= row_base_d;
      num_rows_q   <= num_rows_d;
      col_base_q   <= col_base_d;
      num_cols_q   <= num_cols_d;
      num_passes_q <= num_passes_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      pass_idx_q   <= pass_idx_d;
    end
  end

`ifdef GIN_TAGGER_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count RUN cycles where a word is offered but a full FIFO blocks it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == RUN) && s_valid && !s_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gin_stream_tagger.sv
// tb_gin_stream_tagger: directed scenarios for gin_stream_tagger. Expected
// writes come from a nested pass/row/col loop pushed into a scoreboard queue
// and are popped as the DUT writes. Define GIN_TAGGER_PERF_EN to also cover
// the stall counter.
module tb_gin_stream_tagger;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  cfg_row_base, cfg_num_rows, cfg_col_base, cfg_num_cols;
  logic [7:0]  cfg_num_passes;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] data_in;
  logic [3:0]  row_tag, col_tag;
  logic        data_wr_en, tags_wr_en;
  logic        data_full, tags_full;
  logic        busy, done;
`ifdef GIN_TAGGER_PERF_EN
  logic [15:0] stall_cycles;
`endif

  typedef struct {
    logic [63:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  gin_stream_tagger dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_row_base(cfg_row_base), .cfg_num_rows(cfg_num_rows),
    .cfg_col_base(cfg_col_base), .cfg_num_cols(cfg_num_cols),
    .cfg_num_passes(cfg_num_passes),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .row_tag(row_tag), .col_tag(col_tag),
    .data_wr_en(data_wr_en), .tags_wr_en(tags_wr_en),
    .data_full(data_full), .tags_full(tags_full),
    .busy(busy), .done(done)
`ifdef GIN_TAGGER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let outputs settle.
  task automatic applyStimulus(input logic rst, input logic st, input logic vld,
                               input logic df, input logic tf, input logic [63:0] dat);
    @(negedge clk);
    reset     = rst;
    start     = st;
    s_valid   = vld;
    data_full = df;
    tags_full = tf;
    s_data    = dat;
    #1;
  endtask

  // Scramble cfg inputs so that any use after start would show up.
  task automatic scrambleCfg();
    cfg_row_base   = 4'($urandom);
    cfg_num_rows   = 4'($urandom);
    cfg_col_base   = 4'($urandom);
    cfg_num_cols   = 4'($urandom);
    cfg_num_passes = 8'($urandom);
  endtask

  // Run one sweep with full-flag masks per RUN cycle; abort_after > 0
  // asserts reset once that many words have been written.
  task automatic runSweep(input logic [3:0] rb, input logic [3:0] nr,
                          input logic [3:0] cb, input logic [3:0] nc,
                          input logic [7:0] np, input logic [31:0] df_mask,
                          input logic [31:0] tf_mask, input int abort_after);
    int   er, ec, pops, cyc, stall_exp;
    logic df, tf, exp_rdy;
    exp_t e;
    er = (nr == 4'd0) ? 1 : int'(nr);
    ec = (nc == 4'd0) ? 1 : int'(nc);
    sb.delete();
    for (int p = 0; p < int'(np); p++)
      for (int r = 0; r < er; r++)
        for (int c = 0; c < ec; c++) begin
          e.data = {32'hC0DE_0000, 32'(sb.size())};
          e.row  = rb + 4'(r);
          e.col  = cb + 4'(c);
          sb.push_back(e);
        end
    $display("[TB] sweep base=(%0d,%0d) dims=%0dx%0d passes=%0d expecting %0d writes",
             rb, cb, nr, nc, np, sb.size());

    cfg_row_base = rb; cfg_num_rows = nr; cfg_col_base = cb;
    cfg_num_cols = nc; cfg_num_passes = np;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("idle_ready", 64'(s_ready), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    pops = 0; cyc = 0; stall_exp = 0;
    while (sb.size() != 0 && cyc < 200 && !(abort_after > 0 && pops == abort_after)) begin
      df = (cyc < 32) ? df_mask[cyc] : 1'b0;
      tf = (cyc < 32) ? tf_mask[cyc] : 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, df, tf, {32'hC0DE_0000, 32'(pops)});
      scrambleCfg();
      exp_rdy = ~df & ~tf;
      if (!exp_rdy) stall_exp++;
      checkOutput("s_ready", 64'(s_ready), 64'(exp_rdy));
      checkOutput("busy_run", 64'(busy), 64'd1);
      checkOutput("data_wr_en", 64'(data_wr_en), 64'(exp_rdy));
      checkOutput("tags_wr_en", 64'(tags_wr_en), 64'(exp_rdy));
`ifdef GIN_TAGGER_PERF_EN
      if (cyc == 0) checkOutput("stall_clr", 64'(stall_cycles), 64'd0);
`endif
      if (data_wr_en === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("row_tag", 64'(row_tag), 64'(e.row));
        checkOutput("col_tag", 64'(col_tag), 64'(e.col));
        checkOutput("data_in", data_in, e.data);
        pops++;
      end
      cyc++;
    end
    if (cyc >= 200) checkOutput("timeout", 64'(sb.size()), 64'd0);

    if (abort_after > 0) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("rst_cyc_wr", 64'(data_wr_en), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDEAD);
      checkOutput("post_rst_busy", 64'(busy), 64'd0);
      checkOutput("post_rst_ready", 64'(s_ready), 64'd0);
      checkOutput("post_rst_wr", 64'(data_wr_en | tags_wr_en), 64'd0);
      checkOutput("post_rst_done", 64'(done), 64'd0);
      checkOutput("post_rst_tags", 64'({row_tag, col_tag}), 64'd0);
      sb.delete();
    end else begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hBEEF);
      checkOutput("done_pulse", 64'(done), 64'd1);
      checkOutput("done_busy", 64'(busy), 64'd1);
      checkOutput("done_ready", 64'(s_ready), 64'd0);
      checkOutput("done_wr", 64'(data_wr_en | tags_wr_en), 64'd0);
`ifdef GIN_TAGGER_PERF_EN
      checkOutput("stall_cnt", 64'(stall_cycles), 64'(stall_exp));
`endif
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hBEEF);
      checkOutput("done_clear", 64'(done), 64'd0);
      checkOutput("idle_again", 64'(busy), 64'd0);
      checkOutput("idle_wr", 64'(data_wr_en), 64'd0);
    end
  endtask

  // Directed sequence: reset, then each scenario in turn.
  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    data_full = 1'b0; tags_full = 1'b0;
    cfg_row_base = '0; cfg_num_rows = '0; cfg_col_base = '0;
    cfg_num_cols = '0; cfg_num_passes = '0;

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
    checkOutput("rst_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_wr", 64'(data_wr_en | tags_wr_en), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_tags", 64'({row_tag, col_tag}), 64'd0);
    checkOutput("rst_data", data_in, 64'h1234_5678_9ABC_DEF0);
`ifdef GIN_TAGGER_PERF_EN
    checkOutput("rst_stall", 64'(stall_cycles), 64'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

    runSweep(4'd0, 4'd2, 4'd0, 4'd3, 8'd1, 32'h0, 32'h0, 0);
    runSweep(4'd0, 4'd2, 4'd0, 4'd3, 8'd1, 32'h0000_001C, 32'h0000_0040, 0);
    runSweep(4'd14, 4'd3, 4'd15, 4'd2, 8'd2, 32'h0, 32'h0, 0);
    runSweep(4'd5, 4'd2, 4'd5, 4'd2, 8'd0, 32'h0, 32'h0, 0);
    runSweep(4'd7, 4'd0, 4'd9, 4'd0, 8'd3, 32'h0, 32'h0, 0);
    runSweep(4'd3, 4'd2, 4'd4, 4'd3, 8'd1, 32'h0, 32'h0, 3);
    runSweep(4'd3, 4'd2, 4'd4, 4'd3, 8'd1, 32'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
